// File: rtl/resta_serie.sv
// Bit-serial N-bit subtractor: d = a - b - b_in, one full-subtractor cell
// and a borrow flip-flop processing one bit per clock, LSB first.
module resta_serie #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         b_out,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_sa;
  logic [N-1:0]   r_sb;
  logic [N-2:0]   r_res;
  logic           r_borrow;
  logic [CW-1:0]  r_cnt;
  logic           r_a_msb;
  logic           r_b_msb;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_d;
  logic           r_b_out;
  logic           r_ovf;

  logic           w_x;
  logic           w_borrow_nxt;
  logic           w_last;
  logic           w_accept;
  logic [N-1:0]   w_res_nxt;

  // Full-subtractor cell on the current LSBs
  assign w_x          = r_sa[0] ^ r_sb[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
  assign w_res_nxt    = {w_x, r_res};
  assign w_last       = (r_cnt == CW'(N - 1));
  assign w_accept     = (r_state == S_IDLE) && start;

  // State register; busy/done registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand shift registers, borrow chain and partial result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else if (w_accept) begin
      r_sa     <= a;
      r_sb     <= b;
      r_res    <= '0;
      r_borrow <= b_in;
      r_cnt    <= '0;
      r_a_msb  <= a[N-1];
      r_b_msb  <= b[N-1];
    end else if (r_state == S_SHIFT) begin
      r_sa     <= {1'b0, r_sa[N-1:1]};
      r_sb     <= {1'b0, r_sb[N-1:1]};
      r_res    <= w_res_nxt[N-1:1];
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Visible results only change on the edge that processes the last bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d     <= '0;
      r_b_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_d     <= w_res_nxt;
      r_b_out <= w_borrow_nxt;
      r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_x);
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign d     = r_d;
  assign b_out = r_b_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_resta_serie.sv
// Self-checking bench for resta_serie (N=4): directed cases, random operands,
// exhaustive sweep, ignored restarts and asynchronous reset mid-operation.
module tb_resta_serie;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         b_out;
  logic         ovf;

  int n_checks;
  int n_fail;

  logic [N-1:0] p_d;
  logic         p_b;
  logic         p_o;

  resta_serie #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input int oa, input int ob, input int obin,
                       output logic [N-1:0] md, output logic mb, output logic mo);
    int r;
    int sa;
    int sb;
    int s;
    r  = oa - ob - obin;
    md = N'(r);
    mb = (r < 0);
    sa = (oa >= 8) ? oa - 16 : oa;
    sb = (ob >= 8) ? ob - 16 : ob;
    s  = sa - sb - obin;
    mo = (s < -8) || (s > 7);
  endtask

  // Called right after a negedge with the DUT idle; returns right after the
  // negedge that follows the return to IDLE. mode 0: start pulse, 1: start held
  // high, 2: extra start pulses during SHIFT.
  task automatic run_op(input logic [N-1:0] oa, input logic [N-1:0] ob,
                        input logic obin, input int mode, input string tag);
    logic [N-1:0] ed;
    logic         eb;
    logic         eo;
    int           busy_n;
    int           done_n;
    busy_n = 0;
    done_n = 0;
    model(int'(oa), int'(ob), int'(obin), ed, eb, eo);
    a = oa; b = ob; b_in = obin; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i <= N + 1; i++) begin
      @(negedge clk);
      busy_n += int'(busy);
      if (done) begin
        done_n++;
        check({tag, " done_pos"}, 32'(i), 32'(N));
      end
      if (i < N)
        check({tag, " held"}, {26'd0, d, b_out, ovf}, {26'd0, p_d, p_b, p_o});
      if (i == N) begin
        check({tag, " d"}, 32'(d), 32'(ed));
        check({tag, " b_out"}, 32'(b_out), 32'(eb));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
      end
      a    = N'($urandom);
      b    = N'($urandom);
      b_in = 1'($urandom);
      case (mode)
        1:       start = 1'b1;
        2:       start = (i == 1 || i == 3);
        default: start = 1'b0;
      endcase
    end
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(N + 1));
    check({tag, " done_count"}, 32'(done_n), 32'd1);
    p_d = ed;
    p_b = eb;
    p_o = eo;
  endtask

  initial begin
    int quiet_done;
    n_checks = 0;
    n_fail   = 0;
    p_d = '0; p_b = 1'b0; p_o = 1'b0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {25'd0, busy, done, d, b_out, ovf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    run_op(4'b0000, 4'b0000, 1'b1, 0, "t1");
    run_op(4'b1111, 4'b0001, 1'b0, 0, "t2a");
    run_op(4'b1111, 4'b1111, 1'b1, 0, "t2b");
    run_op(4'b0000, 4'b1111, 1'b1, 0, "t2c");
    run_op(4'b0101, 4'b1010, 1'b0, 0, "t2d");
    run_op(4'b1010, 4'b0101, 1'b0, 0, "t3a");
    run_op(4'b0001, 4'b1111, 1'b0, 0, "t3b");

    // Idle gap: outputs hold, no spurious done
    quiet_done = 0;
    repeat (3) begin
      @(negedge clk);
      quiet_done += int'(done);
    end
    check("idle hold", {27'd0, d, b_out}, {27'd0, p_d, p_b});
    check("idle no done", 32'(quiet_done), 32'd0);

    for (int k = 0; k < 30; k++)
      run_op(N'($urandom), N'($urandom), 1'($urandom), 0, "rand");

    // Restart attempts during SHIFT must be ignored
    run_op(4'b0110, 4'b0011, 1'b1, 2, "t4");
    quiet_done = 0;
    repeat (8) begin
      @(negedge clk);
      quiet_done += int'(done);
    end
    check("t4 no second done", 32'(quiet_done), 32'd0);
    check("t4 result kept", {27'd0, d, b_out}, {27'd0, p_d, p_b});

    // Asynchronous reset after two SHIFT edges
    a = 4'b1001; b = 4'b0110; b_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t5 async clear", {25'd0, busy, done, d, b_out, ovf}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    p_d = '0; p_b = 1'b0; p_o = 1'b0;
    quiet_done = 0;
    repeat (8) begin
      @(negedge clk);
      quiet_done += int'(done);
    end
    check("t5 no done", 32'(quiet_done), 32'd0);
    run_op(4'b0011, 4'b0101, 1'b0, 0, "t5 post");

    // Exhaustive back-to-back sweep with start held high
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run_op(N'(ia), N'(ib), 1'(ic), 1, "sweep");
    start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
